// File: rtl/delay_request_initiator.sv
// Initiator for the single-outstanding request/ready latency handshake: issues one request pulse per command,
// measures responder latency, enforces a timeout, flags stray ready. Optional statistics: INITIATOR_LAT_STATS_EN.
module delay_request_initiator #(
    parameter int TAG_W      = 4,
    parameter int LAT_W      = 8,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             request,
    input  logic             ready,
    output logic             busy,
    output logic             done,
    output logic [TAG_W-1:0] done_tag,
    output logic [LAT_W-1:0] done_latency,
    output logic             done_timeout,
`ifdef INITIATOR_LAT_STATS_EN
    input  logic             stat_clear,
    output logic [15:0]      stat_count,
    output logic [LAT_W-1:0] stat_max,
    output logic [LAT_W-1:0] stat_min,
    output logic [7:0]       stat_timeouts,
`endif
    output logic             spurious
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GAP_W      = (GAP_LAST_I > 0) ? $clog2(GAP_LAST_I + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_LAST_I);
    localparam logic [LAT_W-1:0] TIMEOUT_CNT = LAT_W'(TIMEOUT);

    state_t             state;
    logic [LAT_W-1:0]   lat_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TAG_W-1:0]   tag_q;
    logic               finish;

    // NOTE: cmd_ready is gated by reset_n so no command is accepted while reset is held.
    assign cmd_ready = (state == IDLE) && reset_n;
    assign busy      = (state != IDLE);
    assign finish    = (state == WAIT) && (ready || (lat_cnt == TIMEOUT_CNT));

    // NOTE: all state and registered outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            gap_cnt      <= '0;
            tag_q        <= '0;
            request      <= 1'b0;
            done         <= 1'b0;
            done_tag     <= '0;
            done_latency <= '0;
            done_timeout <= 1'b0;
            spurious     <= 1'b0;
        end else begin
            request  <= 1'b0;
            done     <= 1'b0;
            spurious <= ready && (state != WAIT);
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        tag_q   <= cmd_tag;
                        lat_cnt <= LAT_W'(1);
                        request <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (finish) begin
                        // ready in the TIMEOUT cycle still counts as a success
                        done         <= 1'b1;
                        done_tag     <= tag_q;
                        done_latency <= lat_cnt;
                        done_timeout <= !ready;
                        gap_cnt      <= '0;
                        state        <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                    else                     gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INITIATOR_LAT_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_count    <= '0;
            stat_max      <= '0;
            stat_min      <= '1;
            stat_timeouts <= '0;
        end else if (stat_clear) begin
            stat_count    <= '0;
            stat_max      <= '0;
            stat_min      <= '1;
            stat_timeouts <= '0;
        end else if (finish) begin
            if (ready) begin
                if (stat_count != 16'hFFFF) stat_count <= stat_count + 16'd1;
                if (lat_cnt > stat_max)     stat_max   <= lat_cnt;
                if (lat_cnt < stat_min)     stat_min   <= lat_cnt;
            end else if (stat_timeouts != 8'hFF) begin
                stat_timeouts <= stat_timeouts + 8'd1;
            end
        end
    end
`else
    // Statistics disabled: the core carries no extra state.
`endif

endmodule

// File: tb/tb_delay_request_initiator.sv
// Scoreboard bench for delay_request_initiator: directed transactions push expected completions,
// a negedge monitor pops and compares them. Statistics checks build when INITIATOR_LAT_STATS_EN is defined.
module tb_delay_request_initiator;

    localparam int TAG_W   = 4;
    localparam int LAT_W   = 8;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [LAT_W-1:0] lat;
        logic             to;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic             cmd_valid, cmd_ready, request, ready, busy, done, done_timeout, spurious;
    logic [TAG_W-1:0] cmd_tag, done_tag;
    logic [LAT_W-1:0] done_latency;

    logic             cmd_valid_g, cmd_ready_g, request_g, ready_g, busy_g, done_g, done_timeout_g, spurious_g;
    logic [TAG_W-1:0] cmd_tag_g, done_tag_g;
    logic [LAT_W-1:0] done_latency_g;

`ifdef INITIATOR_LAT_STATS_EN
    logic             stat_clear, stat_clear_g;
    logic [15:0]      stat_count, stat_count_g;
    logic [LAT_W-1:0] stat_max, stat_min, stat_max_g, stat_min_g;
    logic [7:0]       stat_timeouts, stat_timeouts_g;
`endif

    delay_request_initiator #(.TAG_W(TAG_W), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT), .GAP_CYCLES(0)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag),
        .request(request), .ready(ready), .busy(busy), .done(done), .done_tag(done_tag),
        .done_latency(done_latency), .done_timeout(done_timeout),
`ifdef INITIATOR_LAT_STATS_EN
        .stat_clear(stat_clear), .stat_count(stat_count), .stat_max(stat_max), .stat_min(stat_min),
        .stat_timeouts(stat_timeouts),
`endif
        .spurious(spurious)
    );

    delay_request_initiator #(.TAG_W(TAG_W), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT), .GAP_CYCLES(2)) dut_gap (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_g), .cmd_ready(cmd_ready_g), .cmd_tag(cmd_tag_g),
        .request(request_g), .ready(ready_g), .busy(busy_g), .done(done_g), .done_tag(done_tag_g),
        .done_latency(done_latency_g), .done_timeout(done_timeout_g),
`ifdef INITIATOR_LAT_STATS_EN
        .stat_clear(stat_clear_g), .stat_count(stat_count_g), .stat_max(stat_max_g), .stat_min(stat_min_g),
        .stat_timeouts(stat_timeouts_g),
`endif
        .spurious(spurious_g)
    );

    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   dones_seen = 0, exp_dones = 0, spur_seen = 0, exp_spur = 0;
    int   last_req_cyc = 0, last_ready_cyc = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse; counts spurious pulses.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done) begin
            dones_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_tag",     32'(done_tag),     32'(e.tag));
                check("done_latency", 32'(done_latency), 32'(e.lat));
                check("done_timeout", 32'(done_timeout), 32'(e.to));
            end
        end
        if (reset_n && spurious) spur_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ready_at = cycle of the ready pulse counting the request cycle as 1; 0 = responder silent.
    task automatic do_txn(input logic [TAG_W-1:0] tag, input int ready_at, input bit hold);
        int   stop;
        bit   ok;
        exp_t e;
        stop      = (ready_at > 0) ? ready_at : TIMEOUT;
        cmd_valid = 1'b1;
        cmd_tag   = tag;
        ok        = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        step();
        if (!hold) cmd_valid = 1'b0;
        cmd_tag      = ~tag;
        last_req_cyc = cyc;
        check("request_rise", 32'(request), 32'd1);
        check("busy_issue",   32'(busy),    32'd1);
        e.tag = tag;
        e.lat = LAT_W'(stop);
        e.to  = (ready_at == 0);
        exp_q.push_back(e);
        exp_dones++;
        for (int c = 2; c <= stop; c++) begin
            step();
            if (c == 2) check("request_single", 32'(request), 32'd0);
            if (c == stop && ready_at > 0) begin
                ready          = 1'b1;
                last_ready_cyc = cyc;
            end
        end
        step();
        ready = 1'b0;
    endtask

    task automatic wait_req_g(output int at);
        at = -1;
        for (int i = 0; i < 50; i++) begin
            if (request_g) begin
                at = cyc;
                break;
            end
            step();
        end
        if (at < 0) check("gap_request_wait", 32'(request_g), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_ready, r1, r2;
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_tag = '0; ready = 1'b0;
        cmd_valid_g = 1'b0; cmd_tag_g = '0; ready_g = 1'b0;
`ifdef INITIATOR_LAT_STATS_EN
        stat_clear = 1'b0; stat_clear_g = 1'b0;
`endif
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_request",   32'(request),   32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_latency",   32'(done_latency), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_busy",      32'(busy),      32'd0);

        // cmd_valid dropped before the edge: no handshake
        cmd_valid = 1'b1; cmd_tag = 4'h9;
        #3 cmd_valid = 1'b0;
        step();
        check("glitch_busy", 32'(busy), 32'd0);

        do_txn(4'h3, 5, 1'b0);
        repeat (2) step();

        // silent responder, then a late ready while idle
        do_txn(4'hA, 0, 1'b0);
        repeat (2) step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        exp_spur++;
        step();
        check("late_ready_spurious", 32'(spur_seen), 32'(exp_spur));
        check("late_ready_idle",     32'(busy),      32'd0);

        // back-to-back with cmd_valid held, GAP_CYCLES=0
        do_txn(4'h5, 4, 1'b1);
        t_ready = last_ready_cyc;
        do_txn(4'h6, 3, 1'b0);
        check("b2b_spacing", 32'(last_req_cyc - t_ready), 32'd2);

        // ready exactly at lat_cnt == TIMEOUT
        do_txn(4'h7, TIMEOUT, 1'b0);
        repeat (2) step();

        // GAP_CYCLES=2 instance
        cmd_valid_g = 1'b1; cmd_tag_g = 4'hC;
        wait_req_g(r1);
        repeat (2) step();
        ready_g = 1'b1;
        t_ready = cyc;
        step();
        ready_g = 1'b0;
        check("gap_done",      32'(done_g),         32'd1);
        check("gap_latency",   32'(done_latency_g), 32'd3);
        check("gap_tag",       32'(done_tag_g),     32'hC);
        check("gap_cmd_ready", 32'(cmd_ready_g),    32'd0);
        wait_req_g(r2);
        check("gap_spacing", 32'(r2 - t_ready), 32'd4);
        cmd_valid_g = 1'b0;
        repeat (2) step();
        ready_g = 1'b1;
        step();
        ready_g = 1'b0;
        repeat (4) step();

        // reset in the middle of WAIT discards the transaction
        cmd_valid = 1'b1; cmd_tag = 4'h2;
        step();
        cmd_valid = 1'b0;
        repeat (2) step();
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy",      32'(busy),      32'd0);
        check("async_rst_request",   32'(request),   32'd0);
        check("async_rst_done",      32'(done),      32'd0);
        check("async_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        #3 reset_n = 1'b1;
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        exp_spur++;
        step();
        check("post_reset_spurious", 32'(spur_seen), 32'(exp_spur));
        repeat (TIMEOUT + 4) step();
        check("post_reset_idle", 32'(busy), 32'd0);

`ifdef INITIATOR_LAT_STATS_EN
        do_txn(4'h1, 3, 1'b0);
        do_txn(4'h2, 7, 1'b0);
        do_txn(4'h3, 5, 1'b0);
        do_txn(4'h4, 0, 1'b0);
        check("stat_count",    32'(stat_count),    32'd3);
        check("stat_max",      32'(stat_max),      32'd7);
        check("stat_min",      32'(stat_min),      32'd3);
        check("stat_timeouts", 32'(stat_timeouts), 32'd1);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        check("clr_count",    32'(stat_count),    32'd0);
        check("clr_max",      32'(stat_max),      32'd0);
        check("clr_min",      32'(stat_min),      32'hFF);
        check("clr_timeouts", 32'(stat_timeouts), 32'd0);
`endif

        repeat (3) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("done_count",         32'(dones_seen),   32'(exp_dones));
        check("spurious_total",     32'(spur_seen),    32'(exp_spur));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_request_initiator.md
Name: delay_request_initiator

Overview:
- Initiator side of the single-outstanding request/ready latency handshake used by the NPC random-delay responder.
- Accepts commands from an upstream agent and issues a one-cycle `request` pulse to the responder.
- Waits for the responder's one-cycle `ready` pulse, then reports completion with the measured latency.
- Enforces a timeout and flags stray `ready` pulses; this is the bus-master model for latency-tolerance testing.

Parameters:
- TAG_W, 4: width of the command tag carried through to completion.
- LAT_W, 8: width of the latency counter and latency outputs.
- TIMEOUT, 64: latency in cycles at which a transaction is abandoned. Legal range 2 to 2^LAT_W-1.
- GAP_CYCLES, 0: idle cycles inserted after each completion before the next command is accepted.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  upstream command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_tag  in  TAG_W  tag of the offered command.
- request  out  1  one-cycle request pulse to the responder.
- ready  in  1  one-cycle completion pulse from the responder.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- done_tag  out  TAG_W  tag of the completed command.
- done_latency  out  LAT_W  measured latency.
- done_timeout  out  1  completion was a timeout.
- spurious  out  1  one-cycle pulse: `ready` seen outside WAIT.

Behaviour:
- Reset (async assert, sync-free release): state=IDLE, lat_cnt=0, gap_cnt=0. All outputs 0, except cmd_ready=1 once reset_n is high.
- States and transitions:
  - IDLE: cmd_ready=1 (combinational from state). On handshake, latch cmd_tag and go to ISSUE.
  - ISSUE: request=1 (registered; high for exactly one cycle). lat_cnt=1. Always go to WAIT.
  - WAIT: lat_cnt increments by 1 each cycle, so the cycle-k value is k counting the ISSUE cycle as 1.
    - If ready=1: success. done_latency=current lat_cnt, done_timeout=0.
    - Else if lat_cnt==TIMEOUT: timeout. done_latency=TIMEOUT, done_timeout=1.
    - On either exit, go to GAP if GAP_CYCLES>0, otherwise IDLE.
  - GAP: counts GAP_CYCLES cycles, then goes to IDLE. cmd_ready=0.
- done, done_tag, done_latency and done_timeout are registered and valid the cycle after the exit condition. done is high for one cycle; the data fields hold until the next done.
- request never stays high for two consecutive cycles. The responder samples `request` only while idle, so a held request would spawn a duplicate transaction.
- Minimum spacing with GAP_CYCLES=0: ready sampled at cycle T, done at T+1, earliest next request at T+2.
- Boundary rules:
  - ready=1 in the same WAIT cycle that lat_cnt==TIMEOUT: success wins (done_timeout=0, latency=TIMEOUT).
  - ready=1 in IDLE, ISSUE or GAP (e.g. a late reply after a timeout): spurious=1 the next cycle. No state change, no done.
  - cmd_valid dropped before handshake: no effect. The tag is sampled only on handshake.
  - reset_n asserted mid-transaction: request, done and busy drop immediately. The in-flight transaction is discarded with no done. A later responder ready is reported as spurious.
  - lat_cnt never wraps, since TIMEOUT < 2^LAT_W.

Optional Feature:
- Macro: INITIATOR_LAT_STATS_EN.
- Defined: adds the following ports.
  - stat_clear  in  1  synchronous clear of the statistics.
  - stat_count  out  16  successful completions; saturates at 16'hFFFF.
  - stat_max  out  LAT_W  largest success latency; reset value 0.
  - stat_min  out  LAT_W  smallest success latency; reset value all-ones.
  - stat_timeouts  out  8  timeout completions; saturates at 8'hFF.
  - Statistics update in the same cycle done is asserted. Timeouts never touch stat_min/stat_max. stat_clear wins over a simultaneous update.
- Undefined: these ports and registers are absent; core behaviour is identical.

Test Plan:
1. cmd_tag=3 handshake; bench responder pulses ready in the 5th cycle counting the request cycle as 1 -> request high exactly 1 cycle; one cycle after ready, done=1, done_tag=3, done_latency=5, done_timeout=0.
2. TIMEOUT=16, responder silent -> done=1, done_timeout=1, done_latency=16; a later ready pulse while in IDLE -> spurious=1, no done.
3. cmd_valid held high for 2 commands, GAP_CYCLES=0, ready at cycle T -> second request rises at T+2. With GAP_CYCLES=2 -> second request rises at T+4.
4. TIMEOUT=16, ready arrives exactly when lat_cnt=16 -> done_timeout=0, done_latency=16.
5. reset_n pulsed low during WAIT -> request/busy/done go 0 asynchronously; after release, a responder ready pulse -> spurious=1, no done.
6. (INITIATOR_LAT_STATS_EN) successes with latencies 3, 7, 5 plus one timeout -> stat_count=3, stat_max=7, stat_min=3, stat_timeouts=1; then stat_clear -> stat_count=0, stat_max=0, stat_min=all-ones, stat_timeouts=0.
